// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI byte-stream front end.
// TX entries carry the frame-end flag alongside the data byte.
package spi_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int BYTE_W    = 8;
  localparam int TX_W      = 9;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_entry_t;

  typedef enum logic {
    FR_OPEN,
    FR_DRAIN
  } frame_st_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// Caller guarantees push/pop legality; rdata reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push}
                 - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = (cnt == '0) ? '0 : mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/spi_burst_ctrl.sv
// Host byte-stream front end for the SPI master: TX queue with
// frame gating, in-flight tracking and an RX queue with overflow.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_rd,
  input  logic       ovf_clr,
  output logic       rx_overflow,
  output logic       busy,
  output logic       spi_en,
  output logic [7:0] spi_tx_byte,
  input  logic       spi_tx_ready,
  input  logic       spi_rx_ready,
  input  logic [7:0] spi_rx_byte
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  tx_entry_t   tx_in;
  tx_entry_t   tx_head;
  logic [AW:0] tx_cnt;
  logic [AW:0] rx_cnt;
  logic        tx_empty;
  logic        tx_full;
  logic        tx_push;
  logic        tx_pop;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_push;
  logic        rx_pop;
  logic        ovf_set;
  logic        drain_done;
  logic        ovf_q;
  logic [1:0]  inflight;
  logic [1:0]  inflight_nxt;
  frame_st_t   fr_st;
  frame_st_t   fr_nxt;

  assign tx_in    = '{last: tx_last, data: tx_data};
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_push  = tx_valid && !tx_full;
  assign tx_pop   = spi_tx_ready && !tx_empty;

  sync_fifo #(
    .WIDTH(TX_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_tx_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (tx_push),
    .wdata(tx_in),
    .pop  (tx_pop),
    .rdata(tx_head),
    .count(tx_cnt)
  );

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_push  = spi_rx_ready && (!rx_full || rx_pop);
  assign ovf_set  = spi_rx_ready && rx_full && !rx_pop;

  sync_fifo #(
    .WIDTH(BYTE_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_rx_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rx_push),
    .wdata(spi_rx_byte),
    .pop  (rx_pop),
    .rdata(rx_data),
    .count(rx_cnt)
  );

  // The frame's final reply lands when the last byte leaves flight.
  assign drain_done = spi_rx_ready && !spi_tx_ready
                   && (inflight == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fr_st <= FR_OPEN;
    else        fr_st <= fr_nxt;
  end

  always_comb begin
    fr_nxt = fr_st;
    unique case (fr_st)
      FR_OPEN: begin
        if (tx_pop && tx_head.last) fr_nxt = FR_DRAIN;
      end
      FR_DRAIN: begin
        if (drain_done && !(tx_pop && tx_head.last))
          fr_nxt = FR_OPEN;
      end
      default: fr_nxt = FR_OPEN;
    endcase
  end

  assign inflight_nxt = inflight + {1'b0, spi_tx_ready}
                                 - {1'b0, spi_rx_ready};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign tx_ready    = !tx_full;
  assign rx_valid    = !rx_empty;
  assign rx_overflow = ovf_q;
  assign busy        = !tx_empty || (inflight != 2'd0);
  assign spi_en      = !tx_empty && (fr_st == FR_OPEN);
  assign spi_tx_byte = tx_head.data;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: behavioural SPI master that echoes
// each byte XOR 0x99, queue-based reference, random traffic.
module tb_spi_burst_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       ovf_clr;
  logic       rx_overflow;
  logic       busy;
  logic       spi_en;
  logic [7:0] spi_tx_byte;
  logic       spi_tx_ready;
  logic       spi_rx_ready;
  logic [7:0] spi_rx_byte;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  spi_burst_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .ovf_clr     (ovf_clr),
    .rx_overflow (rx_overflow),
    .busy        (busy),
    .spi_en      (spi_en),
    .spi_tx_byte (spi_tx_byte),
    .spi_tx_ready(spi_tx_ready),
    .spi_rx_ready(spi_rx_ready),
    .spi_rx_byte (spi_rx_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI master
  typedef enum {M_IDLE, M_START, M_TRANS, M_STOP} mst_t;
  mst_t       m_st = M_IDLE;
  int         m_cnt = 0;
  int         m_tcyc = 0;
  int         m_flen = 0;
  int         m_frames = 0;
  logic [7:0] m_sh = 8'h00;
  logic       m_rxr = 1'b0;
  logic [7:0] m_rxb = 8'h00;

  assign spi_tx_ready = (m_st == M_TRANS) && (m_cnt == 0);
  assign spi_rx_ready = m_rxr;
  assign spi_rx_byte  = m_rxb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_IDLE;
      m_cnt <= 0;
      m_tcyc <= 0;
      m_frames <= 0;
      m_rxr <= 1'b0;
    end else begin
      m_rxr <= 1'b0;
      case (m_st)
        M_IDLE: if (spi_en) begin
          m_st <= M_START;
          m_sh <= spi_tx_byte;
          m_tcyc <= 0;
          m_frames <= m_frames + 1;
        end
        M_START: begin
          m_st <= M_TRANS;
          m_cnt <= 0;
        end
        M_TRANS: begin
          m_tcyc <= m_tcyc + 1;
          if (m_cnt == 15) begin
            m_rxr <= 1'b1;
            m_rxb <= m_sh ^ 8'h99;
            if (spi_en) begin
              m_sh <= spi_tx_byte;
              m_cnt <= 0;
            end else m_st <= M_STOP;
          end else m_cnt <= m_cnt + 1;
        end
        default: begin
          m_flen <= m_tcyc;
          m_st <= M_IDLE;
        end
      endcase
    end
  end

  // Reference: queued TX entries, expected echoes not yet
  // received, RX contents, overflow and frame-drain state.
  logic [8:0] q_tx[$];
  logic [7:0] q_echo[$];
  logic [7:0] q_rx[$];
  bit e_ovf = 1'b0;
  bit e_wait = 1'b0;

  initial begin
    logic acc, rpop;
    logic [8:0] ent;
    logic [7:0] b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_tx.delete();
        q_echo.delete();
        q_rx.delete();
        e_ovf = 1'b0;
        e_wait = 1'b0;
      end else begin
        acc = tx_valid && (q_tx.size() < DEPTH);
        rpop = rx_rd && (q_rx.size() > 0);
        if (spi_tx_ready && q_tx.size() > 0) begin
          ent = q_tx.pop_front();
          if (ent[8]) e_wait = 1'b1;
        end
        if (acc) begin
          q_tx.push_back({tx_last, tx_data});
          q_echo.push_back(tx_data ^ 8'h99);
        end
        if (rpop) void'(q_rx.pop_front());
        if (ovf_clr) e_ovf = 1'b0;
        if (spi_rx_ready && q_echo.size() > 0) begin
          b = q_echo.pop_front();
          if (q_rx.size() < DEPTH) q_rx.push_back(b);
          else e_ovf = 1'b1;
        end
        if (e_wait && q_echo.size() == q_tx.size())
          e_wait = 1'b0;
      end
    end
  end

  initial begin
    logic [8:0] h;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        h = (q_tx.size() > 0) ? q_tx[0] : 9'h000;
        chk("tx_ready", tx_ready, q_tx.size() < DEPTH);
        chk("rx_valid", rx_valid, q_rx.size() > 0);
        chk("rx_data", rx_data,
            (q_rx.size() > 0) ? q_rx[0] : 8'h00);
        chk("rx_overflow", rx_overflow, e_ovf);
        chk("busy", busy, q_echo.size() > 0);
        chk("spi_en", spi_en, (q_tx.size() > 0) && !e_wait);
        chk("spi_tx_byte", spi_tx_byte, h[7:0]);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ovf", rx_overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spi_en", spi_en, 0);
    chk("rst_spi_tx_byte", spi_tx_byte, 0);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    tx_valid = 1'b1;
    tx_data = d;
    tx_last = l;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("push_timeout", 1, 0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_echo.size() != 0 || m_st != M_IDLE) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_txrdy();
    int n;
    n = 0;
    while (!spi_tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("txrdy_timeout", 1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_rx.size() != 0 && n < 50) begin
      rx_rd = 1'b1;
      @(negedge clk);
      n++;
    end
    rx_rd = 1'b0;
  endtask

  initial begin
    int n, f0;
    logic [7:0] d3 [3];
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tx_last = 1'b0;
    rx_rd = 1'b0;
    ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Single-byte frame and start latency
    f0 = m_frames;
    push(8'hA5, 1'b1);
    n = 0;
    while (!spi_en && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!spi_tx_ready && n < 20) begin @(negedge clk); n++; end
    chk("en_to_txrdy", n, 2);
    n = 0;
    while (!(m_st == M_TRANS && m_cnt == 15) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("en_at_lastbit", spi_en, 0);
    wait_idle();
    chk("t1_rx", rx_data, 8'h3C);
    chk("t1_frames", m_frames - f0, 1);
    chk("t1_len", m_flen, 16);
    chk("t1_busy", busy, 0);
    drain();

    // Three bytes in one frame
    f0 = m_frames;
    d3[0] = 8'h11; d3[1] = 8'h22; d3[2] = 8'h33;
    for (int i = 0; i < 3; i++) push(d3[i], i == 2);
    wait_idle();
    chk("t2_frames", m_frames - f0, 1);
    chk("t2_len", m_flen, 48);
    for (int i = 0; i < 3; i++) begin
      chk("t2_order", rx_data, d3[i] ^ 8'h99);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end

    // Two single-byte frames
    f0 = m_frames;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    wait_idle();
    chk("t3_frames", m_frames - f0, 2);
    drain();

    // Fill TX while the previous frame drains
    rx_rd = 1'b1;
    push(8'h55, 1'b1);
    wait_txrdy();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1;
      tx_data = 8'($urandom);
      tx_last = (i == 7);
      @(negedge clk);
    end
    chk("t4_full", tx_ready, 0);
    tx_data = 8'hEE;
    tx_last = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_txrdy();
    @(negedge clk);
    chk("t4_after_pop", tx_ready, 1);
    wait_idle();
    rx_rd = 1'b0;
    drain();

    // RX overflow, clear, and set winning over clear
    for (int i = 0; i < 9; i++) push(8'(8'hC0 + i), i == 8);
    wait_idle();
    chk("t5_ovf", rx_overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t5_clr", rx_overflow, 0);
    push(8'h77, 1'b1);
    n = 0;
    while (!spi_rx_ready && n < 100) begin @(negedge clk); n++; end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t5_setclr", rx_overflow, 1);
    wait_idle();
    drain();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;

    // Reset during the second byte of three
    push(8'h9A, 1'b0);
    push(8'hBC, 1'b0);
    push(8'hDE, 1'b1);
    wait_txrdy();
    @(negedge clk);
    wait_txrdy();
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (spi_en) n++;
    end
    chk("t6_no_en", n, 0);
    chk("t6_frames", m_frames, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data = 8'($urandom);
      tx_last = ($urandom_range(0, 3) == 0);
      rx_rd = ($urandom_range(0, 1) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    rx_rd = 1'b0;
    ovf_clr = 1'b0;
    wait_idle();
    drain();
    chk("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Byte-stream front end for the SPI master: buffers host bytes in a TX FIFO, drives the master's `en`/`tx_byte` so queued bytes go out back-to-back inside one SS-low frame, and collects every received byte into an RX FIFO. Sits directly upstream of the SPI master on its parallel side, on the same clock and reset. Frame boundaries are host-controlled through a per-byte `last` flag.

## Interface
Parameters:
- `DEPTH`, 8, entries per FIFO; power of two, ≥2
- `AW`, 3, log2(`DEPTH`); counters are `AW+1` bits

Ports:
- `clk`  in  1  system clock, shared with the SPI master
- `rst_n`  in  1  asynchronous, active-low reset
- `tx_valid`  in  1  host offers a byte
- `tx_data`  in  8  byte to send
- `tx_last`  in  1  byte ends the current SS frame
- `tx_ready`  out  1  TX FIFO not full
- `rx_valid`  out  1  RX FIFO not empty
- `rx_data`  out  8  RX FIFO head (show-ahead)
- `rx_rd`  in  1  pop RX head; ignored when `rx_valid`=0
- `ovf_clr`  in  1  clears `rx_overflow`
- `rx_overflow`  out  1  sticky: a received byte was dropped
- `busy`  out  1  TX FIFO non-empty or bytes in flight
- `spi_en`  out  1  to master `en`
- `spi_tx_byte`  out  8  to master `tx_byte`
- `spi_tx_ready`  in  1  master pulse: current byte captured into its shift buffer
- `spi_rx_ready`  in  1  master pulse: `spi_rx_byte` valid this cycle
- `spi_rx_byte`  in  8  master received byte

## Operation
- Master contract: samples `en` in IDLE (start frame) and at the last bit slot of each byte (continue if high, else STOP→IDLE); captures `tx_byte` at frame start and at each last-bit slot; pulses `tx_ready` 1 cycle at the first bit slot of every byte; pulses `rx_ready` with `rx_byte` valid 1 cycle after the last bit slot. One byte = 16 clk in TRANS.
- TX FIFO: 9-bit entries {last, data}; push on `tx_valid && tx_ready`. `spi_tx_byte` = head data (0x00 when empty).
- Pop TX head on `spi_tx_ready`. Pop with head.last=1 sets `gate`.
- `spi_en` = TX non-empty && !`gate`. `gate` clears in the cycle `spi_rx_ready` is seen with `inflight`=1 (the last byte's reply); `spi_en` may rise the following cycle.
- `inflight` counter (0..2): +1 on `spi_tx_ready`, −1 on `spi_rx_ready`, both same cycle → unchanged. `busy` = TX non-empty || `inflight`≠0.
- RX FIFO: push `spi_rx_byte` on `spi_rx_ready`. Full and no simultaneous `rx_rd` → byte dropped, `rx_overflow`←1. Full with `rx_rd` same cycle → accepted, count unchanged.
- `rx_overflow`: set wins over `ovf_clr` in the same cycle.
- TX underrun (FIFO empty at a last-bit slot without `last`): master ends the frame; next push starts a new frame. No error flag.
- TX full with push and pop same cycle: push refused (`tx_ready` from registered count).

## Timing
- Reset values: `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00, `rx_overflow`=0, `busy`=0, `spi_en`=0, `spi_tx_byte`=0x00; FIFOs empty, `gate`=0, `inflight`=0.
- `spi_en` and `spi_tx_byte` are combinational from registered FIFO/gate state; no path from `spi_*` inputs to `spi_en` in the same cycle.
- Push into empty TX → `spi_en` high next cycle → master START next edge → `spi_tx_ready` 2 cycles after `spi_en` rises.
- Byte reaching RX: `rx_valid` high the cycle after `spi_rx_ready`.
- `tx_ready` low the cycle after count reaches `DEPTH`; high the cycle after a pop.
- Reset mid-frame: all state cleared immediately; master shares `rst_n`, so no partial frame resumes.

## Structure
- Shared `spi_pkg`: default `DEPTH`, byte width 8, TX entry width 9.
- One sub-module `sync_fifo` (params WIDTH, DEPTH; show-ahead, count output), instantiated twice: TX (9-bit) and RX (8-bit). Control (`gate`, `inflight`, overflow) in the top.

## Test plan
- Push 0xA5(last) → one frame, `spi_tx_ready` once, `spi_en` low at last-bit slot, master reply 0x3C appears as `rx_data`=0x3C, `busy`→0.
- Push 0x11,0x22,0x33(last) before start → single SS-low frame of 48 TRANS cycles, RX holds 0x11-echo order preserved.
- Push 0x01(last),0x02(last) → two frames, `spi_en` low from first pop until its `spi_rx_ready`, second frame starts after master IDLE.
- Fill TX with 8 bytes → `tx_ready`=0; ninth push ignored; after first `spi_tx_ready`, `tx_ready`=1.
- Never read RX, send 9 bytes → 8 stored, `rx_overflow`=1; `ovf_clr` → 0; coincident set+clr → 1.
- Assert `rst_n`=0 during byte 2 of 3 → all outputs at reset values same cycle, no further `spi_en`.
